// File: rtl/shifter_seq.sv
// Sequential 16-bit shifter (SLL/SRA/ROR/pass): four log-stages, one per clk, done 5 cycles after accept.
// start is taken only in IDLE or DONE; while busy it is ignored, so callers must wait for done.
module shifter_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] Shift_In,
  input  logic [3:0]  Shift_Val,
  input  logic [1:0]  Mode,
  output logic [15:0] Shift_Out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, S1, S2, S4, S8, DONE} state_t;

  state_t      state_q;
  logic [15:0] data_q, data_d;
  logic [3:0]  val_q;
  logic [1:0]  mode_q;
  logic        busy_q, done_q;
  logic        stage_en;
  logic [3:0]  stage_amt;

  function automatic logic [15:0] shift_by(input logic [15:0] d, input logic [3:0] amt,
                                           input logic [1:0] m);
    logic [15:0] r;
    case (m)
      2'b00:   r = d << amt;
      2'b01:   r = $unsigned($signed(d) >>> amt);
      2'b10:   r = (d >> amt) | (d << (5'd16 - {1'b0, amt}));
      default: r = d;
    endcase
    return r;
  endfunction

  // Each stage Sn applies a shift of n when bit log2(n) of the latched amount is set.
  always_comb begin
    stage_en  = 1'b0;
    stage_amt = 4'd0;
    case (state_q)
      S1:      begin stage_en = val_q[0]; stage_amt = 4'd1; end
      S2:      begin stage_en = val_q[1]; stage_amt = 4'd2; end
      S4:      begin stage_en = val_q[2]; stage_amt = 4'd4; end
      S8:      begin stage_en = val_q[3]; stage_amt = 4'd8; end
      default: begin stage_en = 1'b0;     stage_amt = 4'd0; end
    endcase
    data_d = stage_en ? shift_by(data_q, stage_amt, mode_q) : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= 16'h0000;
      val_q   <= 4'h0;
      mode_q  <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            data_q  <= Shift_In;
            val_q   <= Shift_Val;
            mode_q  <= Mode;
            state_q <= S1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        S1: begin data_q <= data_d; state_q <= S2; end
        S2: begin data_q <= data_d; state_q <= S4; end
        S4: begin data_q <= data_d; state_q <= S8; end
        S8: begin
          data_q  <= data_d;
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Shift_Out = data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_shifter_seq.sv
// Bench for shifter_seq: directed literal cases, handshake/reset scenarios, then random ops
// against a cycle-count reference model whose result comes from plain shift arithmetic.
module tb_shifter_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] Shift_In = 16'h0;
  logic [3:0]  Shift_Val = 4'h0;
  logic [1:0]  Mode = 2'b00;
  logic [15:0] Shift_Out;
  logic        busy, done;

  int vectors = 0;
  int miscompares = 0;

  shifter_seq dut (
    .clk(clk), .rst(rst), .start(start), .Shift_In(Shift_In), .Shift_Val(Shift_Val),
    .Mode(Mode), .Shift_Out(Shift_Out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_shift(input logic [15:0] x, input logic [3:0] v,
                                            input logic [1:0] m);
    int          n;
    logic [31:0] w;
    logic [15:0] r;
    n = int'(v);
    w = {x, x} >> n;
    case (m)
      2'd0:    r = x << n;
      2'd1:    r = $unsigned($signed(x) >>> n);
      2'd2:    r = w[15:0];
      default: r = x;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = idle, 1..4 = busy cycles, 5 = done cycle.
  int          m_phase = 0;
  logic [15:0] m_res = 16'h0;
  logic [15:0] m_out = 16'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_out   = 16'h0;
    end else if ((m_phase == 0 || m_phase == 5) && start) begin
      m_phase = 1;
      m_res   = ref_shift(Shift_In, Shift_Val, Mode);
    end else if (m_phase >= 1 && m_phase <= 4) begin
      m_phase = m_phase + 1;
      if (m_phase == 5) m_out = m_res;
    end else begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_busy", {15'd0, busy}, {15'd0, (m_phase >= 1 && m_phase <= 4)});
      chk("model_done", {15'd0, done}, {15'd0, (m_phase == 5)});
      if (m_phase == 0 || m_phase == 5) chk("model_out", Shift_Out, m_out);
    end
  end

  task automatic run_op(input string nm, input logic [15:0] in, input logic [3:0] v,
                        input logic [1:0] m, input logic [15:0] exp);
    @(negedge clk);
    start = 1'b1; Shift_In = in; Shift_Val = v; Mode = m;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk(nm, Shift_Out, exp);
    chk({nm, "_done"}, {15'd0, done}, 16'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] in, exp;
    logic [3:0]  v;
    logic [1:0]  m;

    // Reset state, with start and an operand presented during reset (must be ignored).
    start = 1'b1; Shift_In = 16'h8001; Shift_Val = 4'd1; Mode = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_out", Shift_Out, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);

    // First accept on the first edge after release: SLL 8001 by 1.
    rst = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("sll_busy_k", {15'd0, busy}, 16'd1);
    repeat (3) @(negedge clk);
    chk("sll_busy_k3", {15'd0, busy}, 16'd1);
    @(negedge clk);
    chk("sll_8001", Shift_Out, 16'h0002);
    chk("sll_done", {15'd0, done}, 16'd1);
    @(negedge clk);
    chk("sll_done_pulse", {15'd0, done}, 16'd0);
    chk("sll_hold", Shift_Out, 16'h0002);

    run_op("sra_8000_15", 16'h8000, 4'd15, 2'b01, 16'hFFFF);
    run_op("sra_4000_14", 16'h4000, 4'd14, 2'b01, 16'h0001);
    run_op("ror_1234_4",  16'h1234, 4'd4,  2'b10, 16'h4123);
    run_op("ror_a5a5_0",  16'hA5A5, 4'd0,  2'b10, 16'hA5A5);
    run_op("pass_00ff_3", 16'h00FF, 4'd3,  2'b11, 16'h00FF);

    // start in S2 ignored; start held in DONE accepted back-to-back.
    @(negedge clk);
    start = 1'b1; Shift_In = 16'h0F0F; Shift_Val = 4'd4; Mode = 2'b00;   // N0
    @(negedge clk); start = 1'b0;                                        // N1
    @(negedge clk); start = 1'b1; Shift_In = 16'hFFFF; Shift_Val = 4'd1; Mode = 2'b10;
    @(negedge clk); start = 1'b0;                                        // N3
    @(negedge clk);                                                      // N4 (S8)
    start = 1'b1; Shift_In = 16'h8421; Shift_Val = 4'd5; Mode = 2'b01;
    @(negedge clk);                                                      // N5 DONE
    chk("hs_op1", Shift_Out, 16'hF0F0);
    chk("hs_op1_done", {15'd0, done}, 16'd1);
    @(negedge clk); start = 1'b0;                                        // op2 S1
    chk("hs_done_once", {15'd0, done}, 16'd0);
    chk("hs_busy_b2b", {15'd0, busy}, 16'd1);
    repeat (4) @(negedge clk);
    chk("hs_op2", Shift_Out, 16'hFC21);

    // Asynchronous reset mid-cycle in S4 aborts the operation.
    @(negedge clk);
    start = 1'b1; Shift_In = 16'h1357; Shift_Val = 4'd7; Mode = 2'b00;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);                                           // in S4
    #1 rst = 1'b1;
    #1;
    chk("arst_out", Shift_Out, 16'h0000);
    chk("arst_busy", {15'd0, busy}, 16'd0);
    chk("arst_done", {15'd0, done}, 16'd0);
    #1 rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("arst_no_done", {15'd0, done}, 16'd0);
    end
    run_op("post_rst_ror", 16'h8001, 4'd1, 2'b10, 16'hC000);

    // Random ops, noise on inputs while busy, mostly back-to-back.
    @(negedge clk);
    for (int i = 0; i < 10000 && miscompares == 0; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        start = 1'b0;
        @(negedge clk);
      end
      in = 16'($urandom); v = 4'($urandom_range(0, 15)); m = 2'($urandom_range(0, 3));
      exp = ref_shift(in, v, m);
      start = 1'b1; Shift_In = in; Shift_Val = v; Mode = m;
      repeat (4) begin
        @(negedge clk);
        start = 1'($urandom_range(0, 1));
        Shift_In = 16'($urandom); Shift_Val = 4'($urandom); Mode = 2'($urandom);
      end
      @(negedge clk);
      chk("rand_result", Shift_Out, exp);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shifter_seq.md
SHIFTER_SEQ -- requirements
Module: shifter_seq

Interface
REQ-001 Parameters SHALL be none; data width SHALL be fixed at 16 bits and shift amount at 4 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE or DONE.
REQ-005 Shift_In  input  16  operand; sampled only on an accepted start.
REQ-006 Shift_Val  input  4  shift amount, 0-15; sampled only on an accepted start.
REQ-007 Mode  input  2  operation: 00 = SLL, 01 = SRA, 10 = ROR, 11 = pass-through; sampled only on an accepted start.
REQ-008 Shift_Out  output  16  result register, driven continuously from the internal data register.
REQ-009 busy  output  1  high in states S1, S2, S4 and S8.
REQ-010 done  output  1  high only in state DONE; a one-cycle pulse unless a new op is accepted.

Function
REQ-011 The FSM SHALL have states IDLE, S1, S2, S4, S8 and DONE, using a registered state with next-state logic.
REQ-012 Accept: on a clk edge with start=1 in IDLE or DONE, the block SHALL load the data register with Shift_In, latch Shift_Val and Mode, and go to S1.
REQ-013 In IDLE or DONE with start=0, the FSM SHALL go to IDLE (from DONE) or stay in IDLE.
REQ-014 S1 SHALL advance to S2, S2 to S4, S4 to S8, and S8 to DONE, unconditionally, one state per clk.
REQ-015 On leaving stage Sn (n = 1, 2, 4, 8), the data register SHALL be shifted by n positions per the latched Mode if latched Shift_Val bit log2(n) is 1, and held otherwise.
REQ-016 SLL stage: shift left, zero fill.
REQ-017 SRA stage: shift right, fill with bit 15 of the current data register.
REQ-018 ROR stage: rotate right, bits leaving bit 0 re-enter at bit 15.
REQ-019 Mode 11: the data register SHALL hold in every stage, so Shift_Out equals Shift_In.
REQ-020 Result: in DONE, Shift_Out SHALL equal the SLL, SRA, ROR or pass-through of the latched operand by Shift_Val; Shift_Val = 0 yields the operand unchanged in every mode.
REQ-021 Latency: for start accepted at edge k, done SHALL be high during the cycle after edge k+4 (fixed, independent of Shift_Val and Mode).
REQ-022 Shift_Out SHALL hold the last result after DONE until the next accept edge.
REQ-023 Shift_Out SHALL show intermediate values while busy = 1.
REQ-024 start while busy = 1 SHALL be ignored; latched operands and the sequence are unaffected.
REQ-025 start=1 in DONE SHALL be accepted (back-to-back), giving done=1 for exactly one cycle and busy=1 from the next cycle.
REQ-026 Input changes other than on an accept edge SHALL have no effect on the result.

Reset
REQ-027 rst=1 SHALL immediately, without waiting for clk, force state IDLE, data register 16'h0000, latched Shift_Val 4'h0 and Mode 2'b00.
REQ-028 During reset, Shift_Out SHALL be 16'h0000, busy 0 and done 0.
REQ-029 Reset asserted in any state, including mid-operation, SHALL abort the operation; no done SHALL follow.
REQ-030 start SHALL be ignored while rst=1.
REQ-031 The first accept SHALL be possible on the first clk edge after rst deasserts.

Verification
REQ-032 SLL: Shift_In=16'h8001, Shift_Val=1, Mode=00, start at edge k -> busy high after edges k to k+3; done=1 after edge k+4 with Shift_Out=16'h0002.
REQ-033 SRA: Shift_In=16'h8000, Shift_Val=15, Mode=01 -> Shift_Out=16'hFFFF; Shift_In=16'h4000, Shift_Val=14, Mode=01 -> 16'h0001.
REQ-034 ROR and pass-through:
- 16'h1234, Shift_Val=4, Mode=10 -> 16'h4123.
- 16'hA5A5, Shift_Val=0, Mode=10 -> 16'hA5A5.
- 16'h00FF, Shift_Val=3, Mode=11 -> 16'h00FF.
REQ-035 Handshake:
- Op1 started; start with different operands raised in S2 -> ignored, op1 result correct.
- start held in DONE -> op2 accepted, done=1 for exactly one cycle, op2 result correct 5 cycles later.
REQ-036 Reset: rst pulsed mid-clock while in S4 -> Shift_Out=16'h0000, busy=0, done=0 before the next edge; no done follows; a new op afterwards completes correctly.
REQ-037 Random: 10000 random Shift_In/Shift_Val, all four Modes -> Shift_Out in DONE equals the combinational model (Shift_In<<Val, Shift_In>>>Val, (Shift_In>>Val)|(Shift_In<<(16-Val)), Shift_In); the bench SHALL stop on the first mismatch.
